uart_link: RTL and testbench
============================

Name: uart_link

Overview:
- Single-clock, full-duplex UART with a transmitter and a receiver sharing one clock domain.
- Parametrised in data width, parity mode (none/even/odd) and stop bits.
- Adds valid/ready handshakes, per-frame parity and framing error flags, receive overrun detection, start-bit glitch rejection and internal loopback.
- Sits between the system fabric and the serial pins. Successor to the split-clock transmitter/receiver pair.

Parameters:
CLK_FREQ, 100_000_000, clock frequency in Hz
BAUD_RATE, 115_200, bit rate; CPB = CLK_FREQ / BAUD_RATE (floor), must be >= 4 (elaboration error otherwise)
DATA_WIDTH, 8, data bits per frame, legal 5..9
PARITY, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits transmitted, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tx_data  input  DATA_WIDTH  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  transmitter can accept a word
tx  output  1  serial out, idle high
rx  input  1  serial in, asynchronous
rx_data  output  DATA_WIDTH  received word
rx_valid  output  1  rx_data and flags valid
rx_ready  input  1  consumer accepts rx_data
rx_parity_err  output  1  parity mismatch for the current rx_data
rx_frame_err  output  1  first stop bit sampled low for the current rx_data
rx_overrun  output  1  one-cycle pulse: a completed frame was dropped
loopback  input  1  1 = receiver is fed from the internal tx signal

Behaviour:
- Reset (while rst = 1, clk edge):
  - tx = 1, tx_ready = 0; tx_ready = 1 in the first cycle after rst falls.
  - rx_valid = 0, rx_data = 0, all error flags = 0, rx_overrun = 0.
  - Synchroniser flops = 1; both FSMs return to IDLE.
  - Reset mid-frame aborts the frame; no partial output.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = 1 only in IDLE. A word is accepted on an edge with tx_valid & tx_ready, and tx_data is latched.
  - The start bit (tx = 0) begins the next cycle.
  - Each bit lasts exactly CPB cycles. Data is sent LSB first.
  - PARITY is skipped when PARITY = 0. Even mode sends XOR(data); odd mode sends ~XOR(data).
  - STOP holds tx = 1 for STOP_BITS*CPB cycles, then the FSM returns to IDLE.
  - Back-to-back frame period = (1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS)*CPB + 1 cycles.
  - tx_data changes while busy are ignored.
- RX input path:
  - Source = loopback ? internal tx : rx, passed through a 2-flop synchroniser.
  - tx pin is forced to 1 while loopback = 1.
  - loopback may only change while tx_ready = 1 and RX is IDLE. Otherwise in-flight frames may be corrupted or flagged, but the FSMs must never lock up.
- RX FSM: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE → START on synchronised low.
  - START waits CPB/2 cycles and resamples:
    - high → glitch, return to IDLE, no output.
    - low → sample each later bit every CPB cycles (mid-bit).
  - Only the first stop bit is checked.
  - At the stop-bit sample, the frame completes:
    - rx_data is loaded.
    - rx_parity_err = (sampled parity != expected); forced 0 when PARITY = 0.
    - rx_frame_err = (stop sample == 0).
    - The frame is delivered even when errored.
  - After completion: stop = 1 → IDLE; stop = 0 → WAIT_HIGH until the line is high (break produces exactly one frame).
- RX output handshake:
  - rx_valid stays high, with rx_data and flags stable, until a clk edge with rx_valid & rx_ready.
  - Completion while rx_valid = 1 and rx_ready = 0: new frame dropped, old data kept, rx_overrun pulses high for 1 cycle.
  - Completion in the same cycle as the handshake: new frame loaded, rx_valid stays 1, no overrun.
- Latency, loopback: rx_valid rises 2 (synchroniser) + CPB/2 + (DATA_WIDTH + parity)*CPB + CPB cycles after the tx start edge, ±1 cycle.

Test Plan:
- CLK_FREQ=1_000_000, BAUD_RATE=100_000 (CPB=10), even parity, 1 stop; send 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,0,1 at 10 cycles each; tx_ready low 110 cycles, high on cycle 111.
- Odd parity, loopback=1, send 0x3C → internal parity bit 1; rx_valid with rx_data=0x3C, both errors 0; tx pin stays 1 throughout.
- Even parity, drive rx with data 0x01 and parity 0, stop 1 → rx_data=0x01, rx_parity_err=1, rx_frame_err=0.
- rx held low for 300 cycles, then high → exactly one frame: rx_data=0x00, rx_frame_err=1, rx_parity_err=0; no further rx_valid.
- rx low for 3 cycles, then high → no rx_valid; a following valid frame 0x5A is received correctly.
- rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, one rx_overrun pulse at the 0x22 stop sample.
- Assert rst mid-TX frame → tx=1 next cycle, tx_ready=1 after release.

Source files
------------

// File: rtl/uart_link_if.sv
// Fabric-side handshake bundle for uart_link: transmit request path and receive
// delivery path with per-frame status flags.
interface uart_link_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rx_parity_err;
    logic                  rx_frame_err;
    logic                  rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );
    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_link.sv
// Single-clock full-duplex UART: TX/RX FSMs with valid/ready handshakes, parity and
// framing checks, overrun detection, start-glitch rejection and internal loopback.
module uart_link #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic         clk,
    input  logic         rst,
    uart_link_if.slave   bus,
    output logic         tx,
    input  logic         rx,
    input  logic         loopback
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(STOP_BITS * CPB + 1);
    localparam int BIT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t BIT_LAST  = cnt_t'(CPB - 1);
    localparam cnt_t HALF_LAST = cnt_t'(CPB / 2 - 1);
    localparam cnt_t STOP_LAST = cnt_t'(STOP_BITS * CPB - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_link: CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_check
        $error("uart_link: DATA_WIDTH must be 5..9");
    end

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    function automatic logic par_of(input logic [DATA_WIDTH-1:0] d);
        return (PARITY == 2) ? ~(^d) : ^d;
    endfunction

    tx_state_t             tx_state_q, tx_state_d;
    cnt_t                  tx_cnt_q, tx_cnt_d, tx_last;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d, tx_q, tx_d, tx_ready_q, tx_ready_d;

    rx_state_t             rx_state_q, rx_state_d;
    cnt_t                  rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [1:0]            sync_q, sync_d;
    logic                  rx_par_q, rx_par_d, rx_s, done, hs;
    logic                  rx_valid_q, rx_valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;

    // Transmitter: one counter times every bit; STOP uses the longer multi-bit limit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_last    = (tx_state_q == TX_STOP) ? STOP_LAST : BIT_LAST;
        if (tx_state_q == TX_IDLE) begin
            tx_d = 1'b1;
            if (bus.tx_valid && tx_ready_q) begin
                tx_state_d = TX_START;
                tx_shift_d = bus.tx_data;
                tx_par_d   = par_of(bus.tx_data);
                tx_cnt_d   = '0;
                tx_d       = 1'b0;
            end
        end else if (tx_cnt_q != tx_last) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_d = '0;
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
                TX_DATA: begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
                        tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
                TX_PARITY: begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    tx_d       = 1'b1;
                end
            endcase
        end
        tx_ready_d = (tx_state_d == TX_IDLE);
    end

    assign sync_d = {sync_q[0], loopback ? tx_q : rx};
    assign rx_s   = sync_q[1];

    // Receiver: START confirms the low level at half a bit, later bits are sampled mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        done       = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q != HALF_LAST) begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end else begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: begin
                if (rx_cnt_q != BIT_LAST) begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end else begin
                    rx_cnt_d = '0;
                    if (rx_state_q == RX_DATA) begin
                        rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
                        if (rx_bit_q == DATA_LAST)
                            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                        else
                            rx_bit_d = rx_bit_q + 1'b1;
                    end else if (rx_state_q == RX_PARITY) begin
                        rx_par_d   = rx_s;
                        rx_state_d = RX_STOP;
                    end else begin
                        done       = 1'b1;
                        rx_state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
            end
        endcase
    end

    // A completing frame lands only if the output slot is empty or draining this cycle.
    always_comb begin
        hs         = rx_valid_q & bus.rx_ready;
        rx_valid_d = rx_valid_q & ~hs;
        rx_data_d  = rx_data_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        ovr_d      = 1'b0;
        if (done) begin
            if (!rx_valid_q || hs) begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                pe_d       = (PARITY != 0) && (rx_par_q != par_of(rx_shift_q));
                fe_d       = ~rx_s;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign tx                = tx_q | loopback;
    assign bus.tx_ready      = tx_ready_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_parity_err = pe_q;
    assign bus.rx_frame_err  = fe_q;
    assign bus.rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_link.sv
// Bench for uart_link: even-parity instance for pin-level TX/RX scenarios, odd-parity
// instance for loopback; received frames are checked against a scoreboard queue.
module tb_uart_link;
    localparam int CPB = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_e, rx_e, lb_e, tx_o, rx_o, lb_o;
    int   checks = 0, failures = 0;
    int   ovr_e = 0, frames_e = 0;
    exp_t q_e[$], q_o[$];
    exp_t mon_e, mon_o;

    always #5 clk = ~clk;

    uart_link_if #(.DATA_WIDTH(8)) be();
    uart_link_if #(.DATA_WIDTH(8)) bo();

    uart_link #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1))
    u_even (.clk(clk), .rst(rst), .bus(be), .tx(tx_e), .rx(rx_e), .loopback(lb_e));

    uart_link #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1))
    u_odd (.clk(clk), .rst(rst), .bus(bo), .tx(tx_o), .rx(rx_o), .loopback(lb_o));

    // Scoreboard: every delivered frame must match the oldest expected entry.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (be.rx_overrun) ovr_e++;
            if (be.rx_valid && be.rx_ready) begin
                frames_e++;
                checks++;
                if (q_e.size() == 0) begin
                    failures++;
                    $display("FAIL rx_even_unexpected got data=%h pe=%b fe=%b", be.rx_data, be.rx_parity_err, be.rx_frame_err);
                end else begin
                    mon_e = q_e.pop_front();
                    if ({be.rx_data, be.rx_parity_err, be.rx_frame_err} !== mon_e) begin
                        failures++;
                        $display("FAIL rx_even_frame got data=%h pe=%b fe=%b exp data=%h pe=%b fe=%b",
                                 be.rx_data, be.rx_parity_err, be.rx_frame_err, mon_e.data, mon_e.pe, mon_e.fe);
                    end
                end
            end
            if (bo.rx_valid && bo.rx_ready) begin
                checks++;
                if (q_o.size() == 0) begin
                    failures++;
                    $display("FAIL rx_odd_unexpected got data=%h", bo.rx_data);
                end else begin
                    mon_o = q_o.pop_front();
                    if ({bo.rx_data, bo.rx_parity_err, bo.rx_frame_err} !== mon_o) begin
                        failures++;
                        $display("FAIL rx_odd_frame got data=%h pe=%b fe=%b exp data=%h pe=%b fe=%b",
                                 bo.rx_data, bo.rx_parity_err, bo.rx_frame_err, mon_o.data, mon_o.pe, mon_o.fe);
                    end
                end
            end
        end
    end

    task automatic send_rx(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) rx_e = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        rx_e = 1'b1;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (q_e.size() == 0 && q_o.size() == 0) break;
            @(negedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; lb_e = 1'b0; lb_o = 1'b0; rx_e = 1'b1; rx_o = 1'b1;
        be.tx_valid = 1'b0; be.tx_data = '0; be.rx_ready = 1'b1;
        bo.tx_valid = 1'b0; bo.tx_data = '0; bo.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_e, be.tx_ready} !== 2'b10) begin
            failures++; $display("FAIL reset_tx got tx=%b ready=%b exp tx=1 ready=0", tx_e, be.tx_ready);
        end
        checks++;
        if ({be.rx_valid, be.rx_data} !== 9'h0) begin
            failures++; $display("FAIL reset_rx got valid=%b data=%h exp 0", be.rx_valid, be.rx_data);
        end
        checks++;
        if ({be.rx_parity_err, be.rx_frame_err, be.rx_overrun} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got %b%b%b exp 000", be.rx_parity_err, be.rx_frame_err, be.rx_overrun);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({be.tx_ready, bo.tx_ready} !== 2'b11) begin
            failures++; $display("FAIL reset_release_ready got %b%b exp 11", be.tx_ready, bo.tx_ready);
        end
    endtask

    task automatic test_tx_frame;
        logic [7:0]  d;
        logic [10:0] bits;
        d    = 8'hA5;
        bits = {1'b1, ^d, d, 1'b0};
        @(negedge clk);
        be.tx_data = d; be.tx_valid = 1'b1;
        @(negedge clk);
        be.tx_valid = 1'b0; be.tx_data = 8'hFF;
        for (int k = 1; k <= 110; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if ({tx_e, be.tx_ready} !== {bits[(k-1)/10], 1'b0}) begin
                failures++;
                $display("FAIL tx_bit cycle=%0d got tx=%b ready=%b exp tx=%b ready=0", k, tx_e, be.tx_ready, bits[(k-1)/10]);
            end
        end
        @(negedge clk);
        checks++;
        if (be.tx_ready !== 1'b1) begin
            failures++; $display("FAIL tx_ready_return got %b exp 1 at cycle 111", be.tx_ready);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        n = 0;
        be.tx_data = 8'h3C; be.tx_valid = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (be.tx_ready) begin n = i; break; end
        end
        be.tx_valid = 1'b0;
        checks++;
        if (n != 111) begin
            failures++; $display("FAIL back_to_back_period got %0d exp 111", n);
        end
        repeat (120) @(negedge clk);
    endtask

    task automatic test_loopback_odd;
        int  lat;
        logic low_seen;
        lat = -1; low_seen = 1'b0;
        @(negedge clk);
        lb_o = 1'b1; bo.tx_data = 8'h3C; bo.tx_valid = 1'b1;
        q_o.push_back(exp_t'({8'h3C, 1'b0, 1'b0}));
        for (int n = 1; n <= 250; n++) begin
            @(negedge clk);
            bo.tx_valid = 1'b0;
            if (tx_o !== 1'b1) low_seen = 1'b1;
            if (bo.rx_valid && lat < 0) lat = n - 1;
            if (q_o.size() == 0 && lat >= 0) break;
        end
        checks++;
        if (q_o.size() != 0) begin
            failures++; $display("FAIL loopback_timeout pending=%0d exp 0", q_o.size());
        end
        checks++;
        if (lat < 106 || lat > 108) begin
            failures++; $display("FAIL loopback_latency got %0d exp 107+-1", lat);
        end
        for (int i = 0; i < 50 && !bo.tx_ready; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) low_seen = 1'b1;
        end
        checks++;
        if (low_seen !== 1'b0) begin
            failures++; $display("FAIL loopback_tx_pin got low exp held 1");
        end
        lb_o = 1'b0;
    endtask

    task automatic test_parity_err;
        q_e.push_back(exp_t'({8'h01, 1'b1, 1'b0}));
        send_rx(8'h01, 1'b0, 1'b1);
        wait_drain(100);
        checks++;
        if (q_e.size() != 0) begin
            failures++; $display("FAIL parity_err_timeout pending=%0d exp 0", q_e.size());
        end
    endtask

    task automatic test_break;
        int f0;
        f0 = frames_e;
        q_e.push_back(exp_t'({8'h00, 1'b0, 1'b1}));
        @(negedge clk) rx_e = 1'b0;
        repeat (300) @(negedge clk);
        rx_e = 1'b1;
        repeat (150) @(negedge clk);
        checks++;
        if (frames_e - f0 != 1 || q_e.size() != 0) begin
            failures++; $display("FAIL break_frames got %0d exp 1", frames_e - f0);
        end
    endtask

    task automatic test_glitch;
        int f0;
        f0 = frames_e;
        @(negedge clk) rx_e = 1'b0;
        repeat (3) @(negedge clk);
        rx_e = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (frames_e != f0) begin
            failures++; $display("FAIL glitch_frames got %0d exp 0", frames_e - f0);
        end
        q_e.push_back(exp_t'({8'h5A, 1'b0, 1'b0}));
        send_rx(8'h5A, ^8'h5A, 1'b1);
        wait_drain(100);
        checks++;
        if (q_e.size() != 0) begin
            failures++; $display("FAIL glitch_followup_timeout pending=%0d exp 0", q_e.size());
        end
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ovr_e;
        @(negedge clk) be.rx_ready = 1'b0;
        q_e.push_back(exp_t'({8'h11, 1'b0, 1'b0}));
        send_rx(8'h11, ^8'h11, 1'b1);
        send_rx(8'h22, ^8'h22, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (ovr_e - o0 != 1) begin
            failures++; $display("FAIL overrun_pulses got %0d exp 1", ovr_e - o0);
        end
        checks++;
        if ({be.rx_valid, be.rx_data} !== {1'b1, 8'h11}) begin
            failures++; $display("FAIL overrun_hold got valid=%b data=%h exp valid=1 data=11", be.rx_valid, be.rx_data);
        end
        be.rx_ready = 1'b1;
        wait_drain(20);
        repeat (5) @(negedge clk);
        checks++;
        if (q_e.size() != 0 || be.rx_valid !== 1'b0) begin
            failures++; $display("FAIL overrun_drain got pending=%0d valid=%b exp 0 0", q_e.size(), be.rx_valid);
        end
    endtask

    task automatic test_reset_mid_tx;
        @(negedge clk);
        be.tx_data = 8'hC3; be.tx_valid = 1'b1;
        @(negedge clk);
        be.tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_e, be.tx_ready} !== 2'b10) begin
            failures++; $display("FAIL reset_mid_tx got tx=%b ready=%b exp tx=1 ready=0", tx_e, be.tx_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_e, be.tx_ready} !== 2'b11) begin
            failures++; $display("FAIL reset_mid_tx_release got tx=%b ready=%b exp 1 1", tx_e, be.tx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_loopback_odd();
        test_parity_err();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid_tx();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
